// File: rtl/word_byte_ser_pkg.sv
// Shared types and helpers for the word-to-byte serializer.
package word_byte_ser_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // A requested length of 0 or beyond the lane count means "whole word".
    function automatic int eff_len(input int len, input int nbytes);
        if (len == 0 || len > nbytes) begin
            return nbytes;
        end
        return len;
    endfunction

endpackage

// File: rtl/word_byte_ser_byte_sel.sv
// Combinational NBYTES:1 byte mux; an out-of-range select falls back to byte 0.
module word_byte_ser_byte_sel
    import word_byte_ser_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NBYTES*BYTE_W-1:0] data,
    input  logic [SEL_W-1:0]         sel,
    output logic [BYTE_W-1:0]        byte_o
);

    always_comb begin
        byte_o = data[BYTE_W-1:0];
        for (int i = 0; i < NBYTES; i++) begin
            if (sel == SEL_W'(i)) begin
                byte_o = data[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/word_byte_ser.sv
// Word-to-byte serializer: accepts a word with length/order and emits bytes on a
// valid/ready/last stream. Handshakes: a beat transfers on a rising edge where valid && ready.
module word_byte_ser
    import word_byte_ser_pkg::*;
#(
    parameter  int WORD_W = 32,
    localparam int NBYTES = WORD_W / 8,
    localparam int LEN_W  = $clog2(NBYTES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic [LEN_W-1:0]  s_len,
    input  logic              s_msb_first,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic              busy
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               msb_q, msb_d;
    logic [BYTE_W-1:0]  sel_byte;
    logic               load;
    logic               m_hs;
    int                 eff_i;

    word_byte_ser_byte_sel #(
        .NBYTES (NBYTES),
        .SEL_W  (IDX_W)
    ) u_byte_sel (
        .data   (word_q),
        .sel    (idx_q),
        .byte_o (sel_byte)
    );

    // s_ready depends combinationally on m_ready so the next word can load
    // on the same edge that retires the last byte of the current one.
    assign m_valid = (state_q == SHIFT);
    assign m_last  = m_valid && (rem_q == LEN_W'(1));
    assign m_hs    = m_valid && m_ready;
    assign s_ready = !rst && ((state_q == IDLE) || (m_hs && m_last));
    assign m_data  = m_valid ? sel_byte : 8'h00;
    assign busy    = m_valid;
    assign load    = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        msb_d   = msb_q;
        eff_i   = eff_len(int'(s_len), NBYTES);
        if (load) begin
            state_d = SHIFT;
            word_d  = s_data;
            msb_d   = s_msb_first;
            rem_d   = LEN_W'(eff_i);
            idx_d   = s_msb_first ? IDX_W'(eff_i - 1) : '0;
        end else if (m_hs && m_last) begin
            state_d = IDLE;
        end else if (m_hs) begin
            idx_d = msb_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
            rem_d = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            msb_q   <= msb_d;
        end
    end

endmodule

// File: doc/word_byte_ser.md
# word_byte_ser

Parametrised word-to-byte serializer for the debug datapath. Replaces the fixed 32-to-8 byte select with a sequential block. It accepts a WORD_W-bit word with a byte count and an order bit over a valid/ready handshake, then emits the selected bytes one per cycle on a byte stream with valid/ready/last. It sits between the debug register file / memory read path and the byte-wide TAP shift-out logic.

## Interface
- WORD_W, 32, input word width in bits; multiple of 8, ≥ 8
- NBYTES, WORD_W/8, derived localparam; number of byte lanes
- LEN_W, $clog2(NBYTES+1), derived localparam; width of byte count
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input word valid
- s_ready  out  1  block can accept a word this cycle
- s_data  in  WORD_W  word to serialize; byte k = s_data[8k +: 8]
- s_len  in  LEN_W  bytes to emit; 0 or > NBYTES means NBYTES
- s_msb_first  in  1  0: emit byte 0 upward; 1: emit byte len-1 downward
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accepts byte
- m_data  out  8  current byte
- m_last  out  1  current byte is final byte of the word (qualified by m_valid)
- busy  out  1  word in flight (state SHIFT)

## Operation
- States: IDLE, SHIFT.
- IDLE: s_ready=1, m_valid=0. On s_valid&&s_ready, register word, effective length L (1..NBYTES), and order, then go to SHIFT.
- Start index on load: 0 if LSB-first, L-1 if MSB-first. Remaining count is loaded with L.
- SHIFT: m_valid=1, m_data=word[8·idx +: 8], m_last=(remaining==1).
- On m_valid&&m_ready with !m_last: idx ±1 per order, remaining-1.
- On m_valid&&m_ready&&m_last:
  - If s_valid, load the new word and stay in SHIFT (back-to-back).
  - Otherwise go to IDLE.
- s_ready = (state==IDLE) | (m_valid & m_ready & m_last). This is a combinational path m_ready→s_ready, permitted and documented.
- Held word is stable while in SHIFT; s_data changes do not affect bytes in flight.
- m_data, m_last hold stable while m_valid&&!m_ready (AXI-stream rule). m_valid never drops without a handshake.
- Index arithmetic is width $clog2(NBYTES) (min 1). idx never leaves 0..L-1.
- NBYTES==1: every word emits one byte with m_last=1.

## Timing
- Reset (rst=1 at edge): state=IDLE, word reg=0, idx=0, remaining=0. Outputs: s_ready=1 (after reset releases), m_valid=0, m_data=0, m_last=0, busy=0. During rst high, s_ready=0.
- Reset mid-word: in-flight bytes are discarded with no m_last. The next cycle is IDLE.
- Latency: word accepted at edge N → first byte valid from cycle N+1.
- Throughput with m_ready=1: L bytes in L cycles. Back-to-back words have zero idle cycles.
- Backpressure: m_ready=0 stalls idx/remaining indefinitely; no byte lost or duplicated.
- s_valid in SHIFT not on the last handshake: ignored (s_ready=0), word must be held by the source.

## Structure
- Package word_byte_ser_pkg: state enum (IDLE, SHIFT), BYTE_W=8 constant, function eff_len(s_len, NBYTES) for clamping.
- Sub-module byte_sel: parametrised combinational NBYTES:1 byte mux (sel width $clog2(NBYTES)), out-of-range sel → byte 0; used for m_data.
- Single always_ff for state/idx/remaining/word. Output logic in always_comb.

## Test plan
- Reset then LSB-first: s_data=0xAABBCCDD, s_len=4, m_ready=1 → m_data DD,CC,BB,AA on 4 consecutive cycles, m_last only on AA, s_ready high in the AA cycle.
- MSB-first partial: s_data=0x11223344, s_len=2, s_msb_first=1 → 33 then 44, m_last on 44. s_len=0 gives 11,22,33,44.
- Backpressure: 0xDEADBEEF LSB-first, m_ready toggling 1,0,0,1,1,0,1 → EF,BE,AD,DE exactly once each, m_data stable while stalled.
- Back-to-back: words 0x01020304 then 0x05060708, s_valid held, m_ready=1 → 04,03,02,01,08,07,06,05 in 8 consecutive cycles, m_valid never low.
- Reset mid-word: assert rst after second byte of 0xCAFEF00D → next cycle m_valid=0, busy=0. After release, new word 0x000000AA len 1 emits AA with m_last=1.
- Parameter sweep WORD_W=8 and 64: WORD_W=8 any word → single byte with m_last. WORD_W=64, s_len=9 → clamped to 8 bytes.
